seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Memory-mapped four-digit seven-segment display controller for the arcade machine's score panel. Holds two 2-digit BCD counters written over a 1-bit register bus. It time-multiplexes them onto a common-anode display: digits 3–2 show counter B, digits 1–0 show counter A. It emits a one-cycle `rst_out` pulse when counter A rolls over, which the game uses as a round-complete/restart request.

## Interface
- `DIV_WIDTH`, default 18: scan-divider width; the two MSBs select the digit, so each digit is lit for 2^(DIV_WIDTH-2) clocks.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sel`  in  1  write strobe, one write per cycle while high.
- `addr`  in  1  register select: 0 = counter A (digits 1–0), 1 = counter B (digits 3–2).
- `data_in`  in  1  write command: 1 = increment the addressed counter, 0 = clear it to 00.
- `cathode`  out  8  segments, active-low: [0]=a … [6]=g, [7]=dp.
- `anode`  out  4  digit enables, active-low, one-hot: [0] = rightmost digit.
- `rst_out`  out  1  one-cycle pulse on counter A rollover 99→00.

## Operation
- Counters A and B are each two BCD nibbles (tens, units), range 00–99.
- Write occurs on a rising edge with `sel`=1:
  - `data_in`=1: the addressed counter increments in BCD. Units 9→0 carries into tens. 99 wraps to 00.
  - `data_in`=0: the addressed counter clears to 00.
- With `sel`=0, `addr` and `data_in` are ignored.
- `rst_out` is registered. It is 1 for exactly the cycle after an increment of A from 99 to 00, and 0 otherwise. B wrapping never asserts it.
- Scan divider is a free-running `DIV_WIDTH`-bit up-counter. Digit index = divider[DIV_WIDTH-1:DIV_WIDTH-2], mapped as:
  - 0 → A units, anode 1110
  - 1 → A tens, anode 1101
  - 2 → B units, anode 1011
  - 3 → B tens, anode 0111
- Decoder, values 0–9, dp always off: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. Nibbles 10–15 cannot occur; they decode to FF (blank).
- Leading zeros are displayed; there is no blanking.

## Timing
- Reset is asynchronous and active-low. While `rst`=0:
  - counters = 00, divider = 0, `rst_out` = 0
  - `anode` = 1110, `cathode` = C0
- `anode` and `cathode` are registered from the divider MSBs and the selected nibble. They change together, one clock after the divider MSBs change. There is never a cycle where an anode pattern pairs with another digit's segments.
- Write latency:
  - The counter register updates on the strobe edge.
  - `cathode` reflects the new value one clock later, if that digit is active; otherwise at its next scan slot.
- A write during the active slot of its digit updates the display mid-slot; this is allowed.
- Reset asserted mid-scan or mid-write returns everything to reset values immediately. A write pending on the same edge is lost.
- Full scan period is 2^DIV_WIDTH clocks: 262144 at the default, about 2.6 ms at 100 MHz.

## Structure
- Shared package `seg_display_pkg`:
  - segment pattern constants for 0–9 and blank
  - anode one-hot constants
  - `NUM_DIGITS` = 4
  - a BCD digit typedef (4 bits)
- One sub-module, `seg7_decode`: combinational 4-bit BCD → 8-bit active-low cathode.
- Top level contains: two BCD counters, the scan divider, the digit mux, output registers and the `rst_out` register.

## Test plan
- Reset: hold `rst`=0 for 250 µs → `anode`=1110, `cathode`=C0, `rst_out`=0. Release; within one scan, `anode` steps 1110→1101→1011→0111 and `cathode`=C0 in every slot.
- Single A increment (`sel` pulse 1 cycle, `addr`=0, `data_in`=1):
  - `anode`=1110 slot → `cathode`=F9
  - `anode`=1101 slot → `cathode`=C0
- Thirteen B increments (`addr`=1, `data_in`=1):
  - `anode`=1011 → `cathode`=B0
  - `anode`=0111 → `cathode`=F9
  - A unaffected.
- Rollover: A at 01, apply 110 increments.
  - Exactly one `rst_out` pulse, one cycle long, on the 99→00 step.
  - Final A = 11: digits 1 and 0 both show F9.
- Clear: write `data_in`=0 at `addr`=1 → digits 3–2 show C0; counter A and `rst_out` unchanged.
- Async reset mid-scan, with counters nonzero and divider in slot 2 → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the score-panel seven-segment controller.
// Segment patterns are active-low with bit 7 as dp; anode codes are active-low one-hot.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [NUM_DIGITS-1:0] AN_DIG0 = 4'b1110;
  localparam logic [NUM_DIGITS-1:0] AN_DIG1 = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] AN_DIG2 = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] AN_DIG3 = 4'b0111;

  localparam bcd2_t BCD2_ZERO = '{tens: 4'd0, units: 4'd0};

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd2_is_max(input bcd2_t v);
    return (v.tens == 4'd9) && (v.units == 4'd9);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, dp off.
module seg7_decode
  import seg_display_pkg::*;
(
  input  bcd_t       bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit multiplexed score display: counter A on digits 1-0, counter B on digits 3-2.
// Bus writes increment or clear a counter; A wrapping 99->00 raises a one-cycle rst_out.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int DIV_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  addr,
  input  logic                  data_in,
  output logic [7:0]            cathode,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  rst_out
);

  logic [DIV_WIDTH-1:0]  div;
  bcd2_t                 cnt_a, cnt_b;
  logic [1:0]            dig_idx;
  bcd_t                  dig_val;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            seg_next;

  assign dig_idx = div[DIV_WIDTH-1 -: 2];

  always_comb begin
    dig_val = cnt_a.units;
    an_next = AN_DIG0;
    case (dig_idx)
      2'd0: begin dig_val = cnt_a.units; an_next = AN_DIG0; end
      2'd1: begin dig_val = cnt_a.tens;  an_next = AN_DIG1; end
      2'd2: begin dig_val = cnt_b.units; an_next = AN_DIG2; end
      2'd3: begin dig_val = cnt_b.tens;  an_next = AN_DIG3; end
      default: begin dig_val = cnt_a.units; an_next = AN_DIG0; end
    endcase
  end

  seg7_decode u_dec (
    .bcd (dig_val),
    .seg (seg_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // rst_out looks at the pre-write value so it fires only on the 99->00 increment of A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a   <= BCD2_ZERO;
      cnt_b   <= BCD2_ZERO;
      rst_out <= 1'b0;
    end else begin
      rst_out <= sel && !addr && data_in && bcd2_is_max(cnt_a);
      if (sel) begin
        if (!addr) cnt_a <= data_in ? bcd2_inc(cnt_a) : BCD2_ZERO;
        else       cnt_b <= data_in ? bcd2_inc(cnt_b) : BCD2_ZERO;
      end
    end
  end

  // Anode and cathode share one register stage so a digit never shows another's segments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode   <= AN_DIG0;
      cathode <= SEG_0;
    end else begin
      anode   <= an_next;
      cathode <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short scan divider (4 clocks per digit).
module tb_seg_display_ctrl;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       addr = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] cathode;
  logic [3:0] anode;
  logic       rst_out;

  int total = 0;
  int bad   = 0;

  seg_display_ctrl #(.DIV_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .addr    (addr),
    .data_in (data_in),
    .cathode (cathode),
    .anode   (anode),
    .rst_out (rst_out)
  );

  always #5ns clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the given digit's scan slot, then check its segments.
  task automatic see_digit(input int idx, input logic [7:0] exp, input string tag);
    logic [3:0] an_exp;
    int n;
    an_exp = ~(4'b0001 << idx);
    n = 0;
    @(negedge clk);
    while (anode !== an_exp && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_slot"}, {28'd0, anode}, {28'd0, an_exp});
    chk(tag, {24'd0, cathode}, {24'd0, exp});
  endtask

  task automatic wr(input logic a, input logic d, input int n);
    @(negedge clk);
    sel = 1'b1; addr = a; data_in = d;
    repeat (n) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    int n;

    // reset held
    #250us;
    @(negedge clk);
    chk("rst_anode",   {28'd0, anode},   32'hE);
    chk("rst_cathode", {24'd0, cathode}, 32'hC0);
    chk("rst_rst_out", {31'd0, rst_out}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) see_digit(i, 8'hC0, "scan0");

    // single A increment -> 01
    wr(1'b0, 1'b1, 1);
    see_digit(0, 8'hF9, "a1_d0");
    see_digit(1, 8'hC0, "a1_d1");

    // thirteen B increments -> 13
    wr(1'b1, 1'b1, 13);
    see_digit(2, 8'hB0, "b13_d2");
    see_digit(3, 8'hF9, "b13_d3");
    see_digit(0, 8'hF9, "b13_a_d0");
    see_digit(1, 8'hC0, "b13_a_d1");

    // A from 01, 110 increments: wrap on increment 99, final 11
    pulses = 0;
    pulse_at = -1;
    @(negedge clk);
    sel = 1'b1; addr = 1'b0; data_in = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (rst_out) begin
        pulses++;
        pulse_at = i;
      end
    end
    sel = 1'b0;
    @(negedge clk);
    chk("roll_after", {31'd0, rst_out}, 32'd0);
    chk("roll_pulses", pulses, 32'd1);
    chk("roll_at", pulse_at, 32'd99);
    see_digit(0, 8'hF9, "a11_d0");
    see_digit(1, 8'hF9, "a11_d1");
    see_digit(2, 8'hB0, "a11_b_d2");
    see_digit(3, 8'hF9, "a11_b_d3");

    // clear B
    wr(1'b1, 1'b0, 1);
    chk("clr_rst_out", {31'd0, rst_out}, 32'd0);
    see_digit(2, 8'hC0, "clr_d2");
    see_digit(3, 8'hC0, "clr_d3");
    see_digit(0, 8'hF9, "clr_a_d0");
    see_digit(1, 8'hF9, "clr_a_d1");

    // async reset while slot 2 is showing
    n = 0;
    @(negedge clk);
    while (anode !== 4'b1011 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("async_pre_slot", {28'd0, anode}, 32'hB);
    #1ns rst = 1'b0;
    #1ns;
    chk("async_anode",   {28'd0, anode},   32'hE);
    chk("async_cathode", {24'd0, cathode}, 32'hC0);
    chk("async_rst_out", {31'd0, rst_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) see_digit(i, 8'hC0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
